// File: rtl/tpu_ctrl_datapath.sv
// Control and data-staging path for a 2x2 systolic array: registered instruction decode,
// skewed activation feed and capture of the column results during a COMPUTE run.
module tpu_ctrl_datapath #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [15:0]       instruction,
   input  logic [ACC_W-1:0]  a11,
   input  logic [ACC_W-1:0]  a12,
   input  logic [ACC_W-1:0]  a21,
   input  logic [ACC_W-1:0]  a22,
   input  logic [ACC_W-1:0]  acc_in1,
   input  logic [ACC_W-1:0]  acc_in2,
   output logic [ADDR_W-1:0] base_address,
   output logic              load_weight,
   output logic              load_input,
   output logic              valid,
   output logic              store,
   output logic [DATA_W-1:0] a_in1,
   output logic [DATA_W-1:0] a_in2,
   output logic [ACC_W-1:0]  acc1_mem_0,
   output logic [ACC_W-1:0]  acc1_mem_1,
   output logic [ACC_W-1:0]  acc2_mem_0,
   output logic [ACC_W-1:0]  acc2_mem_1,
   output logic              acc1_full,
   output logic              acc2_full
);

   localparam logic [2:0] OP_NOP         = 3'b000;
   localparam logic [2:0] OP_LOAD_ADDR   = 3'b001;
   localparam logic [2:0] OP_LOAD_WEIGHT = 3'b010;
   localparam logic [2:0] OP_LOAD_INPUT  = 3'b011;
   localparam logic [2:0] OP_COMPUTE     = 3'b100;
   localparam logic [2:0] OP_STORE       = 3'b101;

   logic [2:0] op_in;
   logic [2:0] op_p0;
   logic [2:0] cnt_p0;

   function automatic logic [2:0] cnt_sat_inc(input logic [2:0] c);
      return (c == 3'd7) ? c : c + 3'd1;
   endfunction

   function automatic logic [DATA_W-1:0] act_slice(input logic [ACC_W-1:0] w);
      return w[DATA_W-1:0];
   endfunction

   assign op_in = instruction[15:13];

   // Stage p0: registered decode, address latch and compute step counter
   always_ff @(posedge clk) begin
      if (!reset) begin
         op_p0        <= OP_NOP;
         cnt_p0       <= 3'd0;
         base_address <= '0;
      end else begin
         op_p0 <= op_in;
         if (op_in == OP_LOAD_ADDR)
            base_address <= ADDR_W'(instruction[12:0]);
         // A COMPUTE directly following a COMPUTE continues the run; anything else re-arms it.
         cnt_p0 <= (op_in == OP_COMPUTE && valid) ? cnt_sat_inc(cnt_p0) : 3'd0;
      end
   end

   assign load_weight = (op_p0 == OP_LOAD_WEIGHT);
   assign load_input  = (op_p0 == OP_LOAD_INPUT);
   assign valid       = (op_p0 == OP_COMPUTE);
   assign store       = (op_p0 == OP_STORE);

   // Diagonal skew of the activation matrix into the two array rows
   always_comb begin
      a_in1 = '0;
      a_in2 = '0;
      if (valid) begin
         case (cnt_p0)
            3'd0: a_in1 = act_slice(a11);
            3'd1: begin
               a_in1 = act_slice(a12);
               a_in2 = act_slice(a21);
            end
            3'd2: a_in2 = act_slice(a22);
            default: ;
         endcase
      end
   end

   // Stage p1: result capture; column 2 lags column 1 by one step
   always_ff @(posedge clk) begin
      if (!reset) begin
         acc1_mem_0 <= '0;
         acc1_mem_1 <= '0;
         acc2_mem_0 <= '0;
         acc2_mem_1 <= '0;
         acc1_full  <= 1'b0;
         acc2_full  <= 1'b0;
      end else if (valid) begin
         case (cnt_p0)
            3'd0: begin
               acc1_full <= 1'b0;
               acc2_full <= 1'b0;
            end
            3'd2: acc1_mem_0 <= acc_in1;
            3'd3: begin
               acc1_mem_1 <= acc_in1;
               acc1_full  <= 1'b1;
               acc2_mem_0 <= acc_in2;
            end
            3'd4: begin
               acc2_mem_1 <= acc_in2;
               acc2_full  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_tpu_ctrl_datapath.sv
// Scoreboard bench for tpu_ctrl_datapath: a reference model predicts every cycle's outputs,
// a monitor compares them after each rising edge.
module tb_tpu_ctrl_datapath;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 32;

   logic              clk;
   logic              reset;
   logic [15:0]       instruction;
   logic [ACC_W-1:0]  a11, a12, a21, a22, acc_in1, acc_in2;
   logic [ADDR_W-1:0] base_address;
   logic              load_weight, load_input, valid, store;
   logic [DATA_W-1:0] a_in1, a_in2;
   logic [ACC_W-1:0]  acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1;
   logic              acc1_full, acc2_full;

   tpu_ctrl_datapath #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .reset(reset), .instruction(instruction),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .acc_in1(acc_in1), .acc_in2(acc_in2),
      .base_address(base_address), .load_weight(load_weight), .load_input(load_input),
      .valid(valid), .store(store), .a_in1(a_in1), .a_in2(a_in2),
      .acc1_mem_0(acc1_mem_0), .acc1_mem_1(acc1_mem_1),
      .acc2_mem_0(acc2_mem_0), .acc2_mem_1(acc2_mem_1),
      .acc1_full(acc1_full), .acc2_full(acc2_full)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [ADDR_W-1:0] base;
      logic [3:0]        strobes;
      logic [DATA_W-1:0] ain1, ain2;
      logic [ACC_W-1:0]  m10, m11, m20, m21;
      logic              f1, f2;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model state: outputs as they stand after the latest edge
   logic [ADDR_W-1:0] m_base;
   logic [2:0]        m_op;
   int                m_k;       // index of the current cycle within a COMPUTE run, unbounded
   logic [ACC_W-1:0]  m_mem1 [2];
   logic [ACC_W-1:0]  m_mem2 [2];
   logic              m_f1, m_f2;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
      end
   endtask

   function automatic int cur_cnt();
      if (m_op != 3'b100) return 0;
      return (m_k > 7) ? 7 : m_k;
   endfunction

   task automatic step(input logic [2:0] op, input logic [12:0] imm, input logic rst_n,
                       input logic [ACC_W-1:0] x11, input logic [ACC_W-1:0] x12,
                       input logic [ACC_W-1:0] x21, input logic [ACC_W-1:0] x22,
                       input logic [ACC_W-1:0] c1, input logic [ACC_W-1:0] c2);
      exp_t e;
      @(negedge clk);
      reset = rst_n; instruction = {op, imm};
      a11 = x11; a12 = x12; a21 = x21; a22 = x22; acc_in1 = c1; acc_in2 = c2;
      if (!rst_n) begin
         m_base = '0; m_op = 3'b000; m_k = 0;
         m_mem1[0] = '0; m_mem1[1] = '0; m_mem2[0] = '0; m_mem2[1] = '0;
         m_f1 = 1'b0; m_f2 = 1'b0;
      end else begin
         if (m_op == 3'b100) begin
            if (m_k == 0) begin m_f1 = 1'b0; m_f2 = 1'b0; end
            if (m_k == 2) m_mem1[0] = c1;
            if (m_k == 3) begin m_mem1[1] = c1; m_f1 = 1'b1; m_mem2[0] = c2; end
            if (m_k == 4) begin m_mem2[1] = c2; m_f2 = 1'b1; end
         end
         m_k  = (op == 3'b100 && m_op == 3'b100) ? m_k + 1 : 0;
         m_op = op;
         if (op == 3'b001) m_base = imm;
      end
      e.base    = m_base;
      e.strobes = {m_op == 3'b010, m_op == 3'b011, m_op == 3'b100, m_op == 3'b101};
      e.ain1 = '0; e.ain2 = '0;
      if (m_op == 3'b100) begin
         if (m_k == 0) e.ain1 = x11[DATA_W-1:0];
         if (m_k == 1) begin e.ain1 = x12[DATA_W-1:0]; e.ain2 = x21[DATA_W-1:0]; end
         if (m_k == 2) e.ain2 = x22[DATA_W-1:0];
      end
      e.m10 = m_mem1[0]; e.m11 = m_mem1[1]; e.m20 = m_mem2[0]; e.m21 = m_mem2[1];
      e.f1 = m_f1; e.f2 = m_f2;
      exp_q.push_back(e);
   endtask

   // Directed step: activations 1..4, column inputs track the running step count
   task automatic dstep(input logic [2:0] op, input logic [12:0] imm, input logic rst_n);
      int c;
      c = cur_cnt();
      step(op, imm, rst_n, 1, 2, 3, 4, 32'(10 + c), 32'(20 + c));
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("base_address", 64'(base_address), 64'(e.base));
         chk("strobes", 64'({load_weight, load_input, valid, store}), 64'(e.strobes));
         chk("a_in1", 64'(a_in1), 64'(e.ain1));
         chk("a_in2", 64'(a_in2), 64'(e.ain2));
         chk("acc1_mem_0", 64'(acc1_mem_0), 64'(e.m10));
         chk("acc1_mem_1", 64'(acc1_mem_1), 64'(e.m11));
         chk("acc2_mem_0", 64'(acc2_mem_0), 64'(e.m20));
         chk("acc2_mem_1", 64'(acc2_mem_1), 64'(e.m21));
         chk("acc1_full", 64'(acc1_full), 64'(e.f1));
         chk("acc2_full", 64'(acc2_full), 64'(e.f2));
      end
   end

   initial begin
      logic [2:0] op;
      bit         in_run;
      reset = 1'b0; instruction = '0;
      a11 = '0; a12 = '0; a21 = '0; a22 = '0; acc_in1 = '0; acc_in2 = '0;
      m_base = '0; m_op = '0; m_k = 0; m_f1 = 1'b0; m_f2 = 1'b0;
      m_mem1[0] = '0; m_mem1[1] = '0; m_mem2[0] = '0; m_mem2[1] = '0;

      // Reset, address latch and a single weight strobe
      dstep(3'b000, 13'h0, 1'b0);
      dstep(3'b000, 13'h0, 1'b0);
      dstep(3'b001, 13'h000F, 1'b1);
      dstep(3'b010, 13'h1234, 1'b1);
      dstep(3'b011, 13'h0, 1'b1);
      // Full six-cycle COMPUTE, then STORE with flags held
      repeat (6) dstep(3'b100, 13'h0, 1'b1);
      dstep(3'b101, 13'h0, 1'b1);
      dstep(3'b000, 13'h0, 1'b1);
      // Second run re-arms after a gap
      repeat (5) dstep(3'b100, 13'h0, 1'b1);
      dstep(3'b000, 13'h0, 1'b1);
      // Short run: only the first column word is reached
      repeat (3) dstep(3'b100, 13'h0, 1'b1);
      dstep(3'b000, 13'h0, 1'b1);
      // Reset while the step count is 3
      repeat (4) dstep(3'b100, 13'h0, 1'b1);
      dstep(3'b100, 13'h0, 1'b0);
      dstep(3'b000, 13'h0, 1'b1);
      // Unused opcode and NOP leave the address alone
      dstep(3'b001, 13'h1ABC, 1'b1);
      dstep(3'b111, 13'h0555, 1'b1);
      dstep(3'b000, 13'h0AAA, 1'b1);
      dstep(3'b110, 13'h1FFF, 1'b1);
      // Long run past counter saturation
      repeat (10) dstep(3'b100, 13'h0, 1'b1);
      dstep(3'b000, 13'h0, 1'b1);

      // Randomized traffic with COMPUTE runs of random length
      in_run = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (in_run && $urandom_range(0, 9) < 8) op = 3'b100;
         else if ($urandom_range(0, 2) == 0) op = 3'b100;
         else op = 3'($urandom_range(0, 7));
         in_run = (op == 3'b100);
         step(op, 13'($urandom), ($urandom_range(0, 39) != 0),
              $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      end

      repeat (3) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
